// File: rtl/fft_seq_ctrl_if.sv
// Handshake and address bus between the FFT sequencer and its datapath/register bank.
// The master modport is the sequencer side, the slave modport is the surrounding system.
interface fft_seq_ctrl_if #(
    parameter int LOG2N = 3
);
    logic             start_fft;
    logic             done_clr;
    logic             in_valid;
    logic             in_ready;
    logic             ld_we;
    logic [LOG2N-1:0] ld_addr;
    logic             bfly_en;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [LOG2N-1:0] stage;
    logic             out_valid;
    logic             out_ready;
    logic [LOG2N-1:0] rd_addr;
    logic             busy;
    logic             done;

    modport master (
        input  start_fft, done_clr, in_valid, out_ready,
        output in_ready, ld_we, ld_addr, bfly_en, addr_a, addr_b, tw_idx,
               stage, out_valid, rd_addr, busy, done
    );

    modport slave (
        output start_fft, done_clr, in_valid, out_ready,
        input  in_ready, ld_we, ld_addr, bfly_en, addr_a, addr_b, tw_idx,
               stage, out_valid, rd_addr, busy, done
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Load / butterfly / unload sequencer for an in-place radix-2 DIT FFT.
// Optional macro FFT_SEQ_CTRL_ABORT_EN adds an abort input that cancels a run in progress.
module fft_seq_ctrl #(
    parameter int LOG2N    = 3,
    parameter int BFLY_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef FFT_SEQ_CTRL_ABORT_EN
    input  logic           abort,
`endif
    fft_seq_ctrl_if.master bus
);

    localparam int               N          = 1 << LOG2N;
    localparam int               HALF_N     = N / 2;
    localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
    localparam logic [LOG2N-2:0] K_LAST     = (LOG2N-1)'(HALF_N - 1);
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start_q;
    logic [LOG2N-1:0] r_cnt;
    logic [LOG2N-1:0] w_cnt_nxt;
    logic [LOG2N-2:0] r_k;
    logic [LOG2N-2:0] w_k_nxt;
    logic [LOG2N-1:0] r_stage;
    logic [LOG2N-1:0] w_stage_nxt;
    logic [3:0]       r_dcnt;
    logic [3:0]       w_dcnt_nxt;

    logic             w_start_pulse;
    logic             w_abort;
    logic             w_ld_beat;
    logic             w_last_stage;
    logic             w_issue;
    logic             w_unload;
    logic             w_in_stage;

    logic             r_in_ready;
    logic             r_ld_we;
    logic [LOG2N-1:0] r_ld_addr;
    logic             r_bfly_en;
    logic [LOG2N-1:0] r_addr_a;
    logic [LOG2N-1:0] r_addr_b;
    logic [LOG2N-2:0] r_tw_idx;
    logic [LOG2N-1:0] r_stage_o;
    logic             r_out_valid;
    logic [LOG2N-1:0] r_rd_addr;
    logic             r_busy;
    logic             r_done;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Top operand: insert a zero bit at position 'stage' into k.
    function automatic logic [LOG2N-1:0] bfly_addr_a(input logic [LOG2N-2:0] k,
                                                      input logic [LOG2N-1:0] s);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] mask;
        kx   = {1'b0, k};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        return ((kx >> s) << (s + LOG2N'(1))) | (kx & mask);
    endfunction

    function automatic logic [LOG2N-1:0] bfly_addr_b(input logic [LOG2N-2:0] k,
                                                      input logic [LOG2N-1:0] s);
        return bfly_addr_a(k, s) + (LOG2N'(1) << s);
    endfunction

    function automatic logic [LOG2N-2:0] bfly_tw(input logic [LOG2N-2:0] k,
                                                  input logic [LOG2N-1:0] s);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] mask;
        logic [LOG2N-1:0] tw;
        kx   = {1'b0, k};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        tw   = (kx & mask) << (LOG2N'(LOG2N - 1) - s);
        return tw[LOG2N-2:0];
    endfunction

    assign w_start_pulse = bus.start_fft & ~r_start_q;
    assign w_last_stage  = (r_stage == STAGE_LAST);

`ifdef FFT_SEQ_CTRL_ABORT_EN
    assign w_abort = abort && (r_state inside {ST_LOAD, ST_COMPUTE, ST_DRAIN, ST_UNLOAD});
`else
    assign w_abort = 1'b0;
`endif

    // Next-state and counter sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        w_dcnt_nxt  = r_dcnt;
        w_ld_beat   = 1'b0;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_k_nxt     = '0;
            w_stage_nxt = '0;
            w_dcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_pulse) begin
                        w_state_nxt = ST_LOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid && r_in_ready) begin
                        w_ld_beat = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ST_COMPUTE;
                            w_cnt_nxt   = '0;
                            w_stage_nxt = '0;
                            w_k_nxt     = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + LOG2N'(1);
                        end
                    end else begin
                        w_ld_beat = 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    if (r_k != K_LAST) begin
                        w_k_nxt = r_k + (LOG2N-1)'(1);
                    end else if (BFLY_LAT == 0) begin
                        // No pipeline to drain: advance straight to the next stage or unload.
                        w_k_nxt     = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_last_stage ? ST_UNLOAD : ST_COMPUTE;
                        w_stage_nxt = w_last_stage ? r_stage : r_stage + LOG2N'(1);
                    end else begin
                        w_k_nxt     = '0;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (int'(r_dcnt) >= BFLY_LAT - 1) begin
                        w_dcnt_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_last_stage ? ST_UNLOAD : ST_COMPUTE;
                        w_stage_nxt = w_last_stage ? r_stage : r_stage + LOG2N'(1);
                    end else begin
                        w_dcnt_nxt = r_dcnt + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (bus.out_ready && r_out_valid) begin
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ST_DONE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + LOG2N'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_DONE: begin
                    // A fresh start beats a simultaneous done_clr.
                    if (w_start_pulse) begin
                        w_state_nxt = ST_LOAD;
                        w_cnt_nxt   = '0;
                    end else if (bus.done_clr) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Phase qualifiers of the upcoming cycle, used to build the registered outputs
    always_comb begin
        w_issue    = (w_state_nxt == ST_COMPUTE);
        w_unload   = (w_state_nxt == ST_UNLOAD);
        w_in_stage = (w_state_nxt == ST_COMPUTE) || (w_state_nxt == ST_DRAIN);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_stage     <= '0;
            r_dcnt      <= 4'd0;
            r_in_ready  <= 1'b0;
            r_ld_we     <= 1'b0;
            r_ld_addr   <= '0;
            r_bfly_en   <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_tw_idx    <= '0;
            r_stage_o   <= '0;
            r_out_valid <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_q   <= bus.start_fft;
            r_cnt       <= w_cnt_nxt;
            r_k         <= w_k_nxt;
            r_stage     <= w_stage_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_in_ready  <= (w_state_nxt == ST_LOAD);
            r_ld_we     <= w_ld_beat;
            r_ld_addr   <= w_ld_beat ? bitrev(r_cnt) : '0;
            r_bfly_en   <= w_issue;
            r_addr_a    <= w_issue ? bfly_addr_a(w_k_nxt, w_stage_nxt) : '0;
            r_addr_b    <= w_issue ? bfly_addr_b(w_k_nxt, w_stage_nxt) : '0;
            r_tw_idx    <= w_issue ? bfly_tw(w_k_nxt, w_stage_nxt) : '0;
            r_stage_o   <= w_in_stage ? w_stage_nxt : '0;
            r_out_valid <= w_unload;
            r_rd_addr   <= w_unload ? w_cnt_nxt : '0;
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.ld_we     = r_ld_we;
    assign bus.ld_addr   = r_ld_addr;
    assign bus.bfly_en   = r_bfly_en;
    assign bus.addr_a    = r_addr_a;
    assign bus.addr_b    = r_addr_b;
    assign bus.tw_idx    = r_tw_idx;
    assign bus.stage     = r_stage_o;
    assign bus.out_valid = r_out_valid;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
